// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder plus a carry flop adds two N-bit operands LSB-first, one bit per clock.
// Start/busy handshake on the input side; a one-cycle done pulse marks a new registered result.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// state  | meaning
// IDLE   | waiting for start; busy=0
// RUN    | one operand bit per edge; N edges in total
// DONE   | done pulse, result valid; returns to IDLE unconditionally
module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] z,
  output logic         cout
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  sa;
  logic [N-1:0]  sb;
  logic [N-1:0]  acc;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          fa_s;
  logic          fa_c;
  logic [N-1:0]  acc_next;

  full_adder u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  // sum bits enter at the MSB so that after N shifts bit 0 sits at acc[0]
  assign acc_next = N'({fa_s, acc} >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      z     <= '0;
      cout  <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sa    <= x;
            sb    <= y;
            carry <= cin;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= fa_c;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            z     <= acc_next;
            cout  <= fa_c;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at N=8 (directed), N=1 and N=13 (random, continuous start).
// A cycle-level reference model pushes x+y+cin on each accepted start; monitors pop and compare on done.

module tb_serial_adder;

  localparam int MAXW = 13;
  localparam int NRND = 500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_s   [3];
  logic            start_s [3];
  logic [MAXW-1:0] x_s     [3];
  logic [MAXW-1:0] y_s     [3];
  logic            cin_s   [3];
  logic            cont_mode [3];
  logic            to_flag [3];
  logic            end_chk;

  int total = 0;
  int bad   = 0;
  int pops [3];

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int N = (g == 0) ? 8 : ((g == 1) ? 1 : 13);

    logic         busy;
    logic         done;
    logic         cout;
    logic [N-1:0] z;

    serial_adder #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst_s[g]),
      .start (start_s[g]),
      .x     (x_s[g][N-1:0]),
      .y     (y_s[g][N-1:0]),
      .cin   (cin_s[g]),
      .busy  (busy),
      .done  (done),
      .z     (z),
      .cout  (cout)
    );

    logic [N:0] sb_q [$];
    int         m_cnt    = 0;
    int         rst_gen  = 0;
    int         cyc      = 0;

    // reference model: an accepted start is followed by N+1 busy cycles, the last one being done
    always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst_s[g]) begin
        m_cnt = 0;
        sb_q.delete();
        rst_gen = rst_gen + 1;
      end else if (m_cnt == 0) begin
        if (start_s[g]) begin
          sb_q.push_back((N+1)'(x_s[g][N-1:0]) + (N+1)'(y_s[g][N-1:0]) + (N+1)'(cin_s[g]));
          m_cnt = N + 1;
        end
      end else begin
        m_cnt = m_cnt - 1;
      end
    end

    logic [N:0] held     = '0;
    logic [N:0] exp_v;
    int         seen_gen = 0;
    int         last_done = -1;
    logic       end_done = 1'b0;

    always @(negedge clk) begin
      if (rst_gen != seen_gen) begin
        held      = '0;
        seen_gen  = rst_gen;
        last_done = -1;
      end
      if (rst_gen > 0) begin
        total = total + 1;
        if (busy !== (m_cnt > 0)) begin
          bad = bad + 1;
          $display("FAIL cfg%0d busy @%0t: got %b want %b", g, $time, busy, (m_cnt > 0));
        end
        total = total + 1;
        if (done !== (m_cnt == 1)) begin
          bad = bad + 1;
          $display("FAIL cfg%0d done @%0t: got %b want %b", g, $time, done, (m_cnt == 1));
        end
        if (done === 1'b1) begin
          total = total + 1;
          if (sb_q.size() == 0) begin
            bad = bad + 1;
            $display("FAIL cfg%0d unexpected_done @%0t: got done=1 want no pending result", g, $time);
          end else begin
            exp_v = sb_q.pop_front();
            if ({cout, z} !== exp_v) begin
              bad = bad + 1;
              $display("FAIL cfg%0d sum @%0t: got %h want %h", g, $time, {cout, z}, exp_v);
            end
            held = exp_v;
            pops[g] = pops[g] + 1;
            if (cont_mode[g] && last_done >= 0) begin
              total = total + 1;
              if (cyc - last_done != N + 2) begin
                bad = bad + 1;
                $display("FAIL cfg%0d period @%0t: got %0d want %0d", g, $time, cyc - last_done, N + 2);
              end
            end
            last_done = cyc;
          end
        end else begin
          total = total + 1;
          if ({cout, z} !== held) begin
            bad = bad + 1;
            $display("FAIL cfg%0d hold @%0t: got %h want %h", g, $time, {cout, z}, held);
          end
        end
      end
      if (end_chk && !end_done) begin
        end_done = 1'b1;
        total = total + 1;
        if (sb_q.size() != 0) begin
          bad = bad + 1;
          $display("FAIL cfg%0d pending: got %0d outstanding want 0", g, sb_q.size());
        end
        total = total + 1;
        if (to_flag[g]) begin
          bad = bad + 1;
          $display("FAIL cfg%0d timeout: got %0d results want %0d", g, pops[g], NRND);
        end
      end
    end
  end

  task automatic drv(input int g, input logic st, input logic [MAXW-1:0] a,
                     input logic [MAXW-1:0] b, input logic c, input logic r);
    start_s[g] = st;
    x_s[g]     = a;
    y_s[g]     = b;
    cin_s[g]   = c;
    rst_s[g]   = r;
    @(negedge clk);
  endtask

  task automatic idle(input int g, input int n);
    for (int i = 0; i < n; i++)
      drv(g, 1'b0, MAXW'($urandom), MAXW'($urandom), 1'($urandom), 1'b0);
  endtask

  function automatic logic [MAXW-1:0] rnd_op();
    logic [MAXW-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '1;
      1:       v = '0;
      default: v = MAXW'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    for (int g = 0; g < 3; g++) begin
      rst_s[g]     = 1'b1;
      start_s[g]   = 1'b0;
      x_s[g]       = '0;
      y_s[g]       = '0;
      cin_s[g]     = 1'b0;
      cont_mode[g] = 1'b0;
      to_flag[g]   = 1'b0;
      pops[g]      = 0;
    end
    end_chk = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) rst_s[g] = 1'b0;
    @(negedge clk);

    // single add, then a long hold with random operand noise
    drv(0, 1'b1, 13'h5A, 13'h3C, 1'b0, 1'b0);
    idle(0, 30);

    // corner operands
    drv(0, 1'b1, 13'hFF, 13'h01, 1'b0, 1'b0);  idle(0, 11);
    drv(0, 1'b1, 13'hFF, 13'hFF, 1'b1, 1'b0);  idle(0, 11);
    drv(0, 1'b1, 13'h00, 13'h00, 1'b1, 1'b0);  idle(0, 11);

    // start while busy, including the done cycle, must be ignored
    drv(0, 1'b1, 13'h10, 13'h20, 1'b0, 1'b0);
    idle(0, 2);
    drv(0, 1'b1, 13'hAA, 13'h55, 1'b0, 1'b0);
    idle(0, 5);
    drv(0, 1'b1, 13'hAA, 13'h55, 1'b0, 1'b0);
    idle(0, 12);

    // reset mid-operation discards the result
    drv(0, 1'b1, 13'h7F, 13'h01, 1'b0, 1'b0);
    idle(0, 3);
    drv(0, 1'b0, 13'h00, 13'h00, 1'b0, 1'b1);
    idle(0, 16);

    // continuous start with operands changing every cycle, then reset with start high
    for (int i = 0; i < 45; i++)
      drv(0, 1'b1, rnd_op(), rnd_op(), 1'($urandom), 1'b0);
    drv(0, 1'b1, rnd_op(), rnd_op(), 1'b1, 1'b1);
    idle(0, 14);

    // randomized continuous-start runs for the narrow and wide configurations
    for (int g = 1; g < 3; g++) begin
      int limit;
      int cycles;
      limit  = (NRND + 4) * 16;
      cycles = 0;
      cont_mode[g] = 1'b1;
      while (pops[g] < NRND && cycles < limit) begin
        drv(g, 1'b1, rnd_op(), rnd_op(), 1'($urandom), 1'b0);
        cycles++;
      end
      if (pops[g] < NRND) to_flag[g] = 1'b1;
      drv(g, 1'b0, '0, '0, 1'b0, 1'b0);
      cont_mode[g] = 1'b0;
      idle(g, 20);
    end

    end_chk = 1'b1;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
